// File: rtl/clockphase_decoder.sv
// clockphase_decoder: receive side of the MCS-4 two-phase clock; syncs clk1/clk2, strobes edges, checks order/timing, tracks lock.
// Latency: an edge strobe is registered 3 sysclk posedges after the input change is driven (2 sync flops, history flop, output flop).
// Backpressure: none; free-running monitor, all outputs registered. Optional CLOCKPHASE_SUBCYCLE_EN adds sync_in/subcycle/cycle_start.
module clockphase_decoder #(
    parameter int SYSCLK_TCY = 20,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       clk1_in,
    input  logic       clk2_in,
    input  logic       err_clear,
`ifdef CLOCKPHASE_SUBCYCLE_EN
    input  logic       sync_in,
    output logic [2:0] subcycle,
    output logic       cycle_start,
`endif
    output logic       clk1_rise,
    output logic       clk1_fall,
    output logic       clk2_rise,
    output logic       clk2_fall,
    output logic       locked,
    output logic       timing_err,
    output logic       err_sticky
);

    // Nominal MCS-4 intervals expressed in sysclk cycles.
    localparam int NPW = 400 / SYSCLK_TCY;
    localparam int ND1 = 400 / SYSCLK_TCY;
    localparam int ND2 = 200 / SYSCLK_TCY;
    localparam int NCY = 1400 / SYSCLK_TCY;
    localparam int CW  = $clog2(NCY) + 1;
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
    // Which edge is due next in the clk1 rise -> clk1 fall -> clk2 rise -> clk2 fall loop.
    typedef enum logic [1:0] {EXP_C1R, EXP_C1F, EXP_C2R, EXP_C2F} phase_t;

    logic          c1_s1, c1_s2, c1_h;
    logic          c2_s1, c2_s2, c2_h;
    logic          e1r, e1f, e2r, e2f, any_edge, ovl_on;
    logic [3:0]    edges, exp_mask;
    logic [CW-1:0] cnt_q;
    logic [CW:0]   meas;
    state_t        state_q, state_d;
    phase_t        exp_q, exp_d;
    logic [3:0]    good_q, good_d;
    logic          viol;
    int            nom_sel;

    // Pass check for one measured interval against its nominal value.
    function automatic logic in_tol(input logic [CW:0] m, input int nom);
        int d;
        d = int'(m) - nom;
        return (d <= TOL) && (d >= -TOL);
    endfunction

    // Two-flop synchronisers plus a history flop per phase input.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            c1_s1 <= 1'b0; c1_s2 <= 1'b0; c1_h <= 1'b0;
            c2_s1 <= 1'b0; c2_s2 <= 1'b0; c2_h <= 1'b0;
        end else begin
            c1_s1 <= clk1_in; c1_s2 <= c1_s1; c1_h <= c1_s2;
            c2_s1 <= clk2_in; c2_s2 <= c2_s1; c2_h <= c2_s2;
        end
    end

    assign e1r      = c1_s2 & ~c1_h;
    assign e1f      = ~c1_s2 & c1_h;
    assign e2r      = c2_s2 & ~c2_h;
    assign e2f      = ~c2_s2 & c2_h;
    assign edges    = {e2f, e2r, e1f, e1r};
    assign any_edge = |edges;
    assign exp_mask = 4'b0001 << exp_q;
    // Only the onset of overlap is flagged, so a long overlap gives one pulse.
    assign ovl_on   = c1_s2 & c2_s2 & ~(c1_h & c2_h);
    // The counter holds cycles-since-edge minus one when the next edge is seen.
    assign meas     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

    // Interval counter: restarts on every edge, saturates to signal a stopped clock.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (any_edge) begin
            cnt_q <= '0;
        end else if (cnt_q != CMAX) begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Lock state, expected next edge and good-cycle count.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= UNLOCKED;
            exp_q   <= EXP_C1R;
            good_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            good_q  <= good_d;
        end
    end

    // Violation detection and next-state logic; a violation always wins and unlocks.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        good_d  = good_q;
        viol    = 1'b0;
        nom_sel = NPW;
        case (exp_q)
            EXP_C1R: nom_sel = ND2;
            EXP_C1F: nom_sel = NPW;
            EXP_C2R: nom_sel = ND1;
            EXP_C2F: nom_sel = NPW;
            default: nom_sel = NPW;
        endcase

        if (ovl_on) viol = 1'b1;
        if (state_q != UNLOCKED) begin
            if (cnt_q == CMAX) viol = 1'b1;
            if (any_edge) begin
                if (edges != exp_mask) viol = 1'b1;
                else if (!in_tol(meas, nom_sel)) viol = 1'b1;
            end
        end

        if (viol) begin
            state_d = UNLOCKED;
        end else begin
            case (state_q)
                UNLOCKED: begin
                    // This rise opens the first measured cycle; its ND2 gap is unknown.
                    if (e1r) begin
                        state_d = ACQUIRE;
                        good_d  = 4'd0;
                        exp_d   = EXP_C1F;
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (any_edge) begin
                        exp_d = phase_t'(exp_q + 2'd1);
                        if (e2f && state_q == ACQUIRE) begin
                            good_d = good_q + 4'd1;
                            if (good_q == 4'(LOCK_COUNT - 1)) state_d = LOCKED;
                        end
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    // Registered strobes and error reporting; a new error beats a simultaneous clear.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            clk1_rise  <= 1'b0;
            clk1_fall  <= 1'b0;
            clk2_rise  <= 1'b0;
            clk2_fall  <= 1'b0;
            timing_err <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            clk1_rise  <= e1r;
            clk1_fall  <= e1f;
            clk2_rise  <= e2r;
            clk2_fall  <= e2f;
            timing_err <= viol;
            if (viol)           err_sticky <= 1'b1;
            else if (err_clear) err_sticky <= 1'b0;
        end
    end

    assign locked = (state_q == LOCKED);

`ifdef CLOCKPHASE_SUBCYCLE_EN
    logic sync_s1, sync_s2;

    // Instruction subcycle tracker A1..X3, realigned by the CPU SYNC pulse.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_s1     <= 1'b0;
            sync_s2     <= 1'b0;
            subcycle    <= 3'd0;
            cycle_start <= 1'b0;
        end else begin
            sync_s1     <= sync_in;
            sync_s2     <= sync_s1;
            cycle_start <= 1'b0;
            if (state_q != LOCKED) begin
                subcycle <= 3'd0;
            end else if (e2f) begin
                if (sync_s2) begin
                    subcycle    <= 3'd0;
                    cycle_start <= 1'b1;
                end else begin
                    subcycle <= subcycle + 3'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_clockphase_decoder.sv
// tb_clockphase_decoder: drives directed and randomized two-phase clocks into clockphase_decoder.
// Latency: outputs compared every cycle against an interval/event model, plus literal spot checks.
// Backpressure: none; inputs change 1ns after posedge, outputs sampled on negedge or 1ns after posedge.
module tb_clockphase_decoder;
    localparam int TOL        = 2;
    localparam int LOCK_COUNT = 4;
    localparam int TIMEOUT    = 256;  // counter is clog2(70)+1 = 8 bits wide

    logic sysclk = 1'b0;
    logic reset, clk1_in, clk2_in, err_clear;
    logic clk1_rise, clk1_fall, clk2_rise, clk2_fall, locked, timing_err, err_sticky;

    clockphase_decoder #(.SYSCLK_TCY(20), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT)) dut (
        .sysclk(sysclk), .reset(reset), .clk1_in(clk1_in), .clk2_in(clk2_in),
        .err_clear(err_clear), .clk1_rise(clk1_rise), .clk1_fall(clk1_fall),
        .clk2_rise(clk2_rise), .clk2_fall(clk2_fall), .locked(locked),
        .timing_err(timing_err), .err_sticky(err_sticky)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Edges are events at sysclk cycle indices; intervals are index differences.
    int cyc = 0, rst_last = 0, last_edge = 0;
    int m_state = 0;   // 0 unlocked, 1 acquiring, 2 locked
    int m_next  = 0;   // edge kind due next: 0 c1 rise, 1 c1 fall, 2 c2 rise, 3 c2 fall
    int m_good  = 0;
    int terr_seen = 0;
    bit mvalid = 1'b0;
    bit m_c1r, m_c1f, m_c2r, m_c2f, m_terr, m_sticky;
    bit l1 [16];
    bit l2 [16];

    function automatic int nom_of(input int kind);
        case (kind)
            0: return 10;
            default: return 20;
        endcase
    endfunction

    // Input level captured at posedge k, seen as 0 at or before the last reset.
    function automatic bit lv1(input int k);
        return (k > rst_last) ? l1[k % 16] : 1'b0;
    endfunction
    function automatic bit lv2(input int k);
        return (k > rst_last) ? l2[k % 16] : 1'b0;
    endfunction

    // Advance the model over the next posedge, using the inputs it will sample.
    task automatic model_step();
        int n, nk, kind, dt;
        bit a1, a2, p1, p2, c1r, c1f, c2r, c2f, viol;
        cyc++;
        n = cyc;
        l1[n % 16] = clk1_in;
        l2[n % 16] = clk2_in;
        if (reset === 1'b1) begin
            rst_last = n; last_edge = n; m_state = 0;
            {m_c1r, m_c1f, m_c2r, m_c2f, m_terr, m_sticky} = '0;
            mvalid = 1'b1;
            return;
        end
        if (!mvalid) return;
        // Strobe at posedge n reflects the level change captured at n-2 vs n-3.
        a1 = lv1(n - 2); p1 = lv1(n - 3);
        a2 = lv2(n - 2); p2 = lv2(n - 3);
        c1r = a1 & ~p1; c1f = ~a1 & p1;
        c2r = a2 & ~p2; c2f = ~a2 & p2;
        nk   = int'(c1r) + int'(c1f) + int'(c2r) + int'(c2f);
        kind = c1r ? 0 : c1f ? 1 : c2r ? 2 : 3;
        dt   = n - last_edge;
        viol = (a1 & a2) & ~(p1 & p2);
        if (m_state != 0) begin
            if (dt >= TIMEOUT) viol = 1'b1;
            if (nk > 1 || (nk == 1 && kind != m_next)) viol = 1'b1;
            else if (nk == 1 && (dt - nom_of(kind) > TOL || nom_of(kind) - dt > TOL)) viol = 1'b1;
        end
        if (viol) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (c1r) begin m_state = 1; m_good = 0; m_next = 1; end
        end else if (nk == 1) begin
            m_next = (kind + 1) % 4;
            if (kind == 3 && m_state == 1) begin
                m_good++;
                if (m_good == LOCK_COUNT) m_state = 2;
            end
        end
        if (nk > 0) last_edge = n;
        m_c1r = c1r; m_c1f = c1f; m_c2r = c2r; m_c2f = c2f;
        m_terr = viol;
        if (viol) m_sticky = 1'b1;
        else if (err_clear === 1'b1) m_sticky = 1'b0;
    endtask

    // Per-cycle compare against the model, then step it.
    always @(negedge sysclk) begin
        if (mvalid) begin
            chk("clk1_rise", clk1_rise, m_c1r);
            chk("clk1_fall", clk1_fall, m_c1f);
            chk("clk2_rise", clk2_rise, m_c2r);
            chk("clk2_fall", clk2_fall, m_c2f);
            chk("locked", locked, m_state == 2);
            chk("timing_err", timing_err, m_terr);
            chk("err_sticky", err_sticky, m_sticky);
        end
        if (timing_err === 1'b1) terr_seen++;
        model_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive_cycle(input int h1, input int g1, input int h2, input int g2);
        clk1_in = 1'b1; repeat (h1) tick();
        clk1_in = 1'b0; repeat (g1) tick();
        clk2_in = 1'b1; repeat (h2) tick();
        clk2_in = 1'b0; repeat (g2) tick();
    endtask

    function automatic int jit(input int nom);
        if ($urandom_range(0, 1) == 1) return nom + int'($urandom_range(0, 6)) - 3;
        return nom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, t0;
        reset = 1'b1; clk1_in = 1'b0; clk2_in = 1'b0; err_clear = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_locked", locked, 1'b0);
        chk("reset_sticky", err_sticky, 1'b0);

        // First cycle doubles as the edge-latency check.
        clk1_in = 1'b1;
        tick(); tick(); chk("rise_early", clk1_rise, 1'b0);
        tick();         chk("rise_latency", clk1_rise, 1'b1);
        tick();         chk("rise_width", clk1_rise, 1'b0);
        repeat (16) tick();
        clk1_in = 1'b0; repeat (20) tick();
        clk2_in = 1'b1; repeat (20) tick();
        clk2_in = 1'b0; repeat (10) tick();
        repeat (2) drive_cycle(20, 20, 20, 10);
        clk1_in = 1'b1; repeat (20) tick();
        clk1_in = 1'b0; repeat (20) tick();
        clk2_in = 1'b1; repeat (20) tick();
        clk2_in = 1'b0;
        tick(); tick(); chk("lock_early", locked, 1'b0);
        tick();         chk("lock_4th_fall", locked, 1'b1);
        chk("lock_strobe", clk2_fall, 1'b1);
        repeat (7) tick();
        chk_int("nominal_no_err", terr_seen, 0);

        // 22-cycle clk1 pulse is inside tolerance.
        drive_cycle(22, 20, 20, 10);
        chk("pw22_locked", locked, 1'b1);
        chk_int("pw22_no_err", terr_seen, 0);

        // 23-cycle clk1 pulse is one cycle too long.
        clk1_in = 1'b1; repeat (23) tick();
        clk1_in = 1'b0; repeat (3) tick();
        chk("pw23_err", timing_err, 1'b1);
        chk("pw23_unlock", locked, 1'b0);
        chk("pw23_sticky", err_sticky, 1'b1);
        tick();
        chk("pw23_err_pulse", timing_err, 1'b0);
        repeat (16) tick();
        clk2_in = 1'b1; repeat (20) tick();
        clk2_in = 1'b0; repeat (10) tick();
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("clear_sticky", err_sticky, 1'b0);
        repeat (4) drive_cycle(20, 20, 20, 10);
        chk("relock1", locked, 1'b1);

        // clk2 raised while clk1 high.
        t0 = terr_seen;
        clk1_in = 1'b1; repeat (10) tick();
        clk2_in = 1'b1; repeat (3) tick();
        chk("ovl_err", timing_err, 1'b1);
        chk("ovl_unlock", locked, 1'b0);
        tick();
        chk("ovl_err_pulse", timing_err, 1'b0);
        repeat (6) tick();
        clk1_in = 1'b0; repeat (10) tick();
        clk2_in = 1'b0; repeat (10) tick();
        chk_int("ovl_single_pulse", terr_seen - t0, 1);
        chk("ovl_sticky", err_sticky, 1'b1);
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("ovl_clear", err_sticky, 1'b0);
        repeat (4) drive_cycle(20, 20, 20, 10);
        chk("relock2", locked, 1'b1);

        // Stopped clock: last clk2_fall strobe lands 3 cycles into the 10-cycle gap.
        k = 0;
        while (timing_err !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        chk_int("timeout_cycles", k, TIMEOUT - 7);
        chk("timeout_unlock", locked, 1'b0);
        repeat (4) drive_cycle(20, 20, 20, 10);
        chk("relock3", locked, 1'b1);

        // Reset in the middle of a clk1 high pulse.
        clk1_in = 1'b1; repeat (5) tick();
        reset = 1'b1; tick();
        chk("rst_mid_locked", locked, 1'b0);
        chk("rst_mid_rise", clk1_rise, 1'b0);
        chk("rst_mid_err", timing_err, 1'b0);
        chk("rst_mid_sticky", err_sticky, 1'b0);
        reset = 1'b0;
        repeat (14) tick();
        clk1_in = 1'b0; repeat (20) tick();
        clk2_in = 1'b1; repeat (20) tick();
        clk2_in = 1'b0; repeat (10) tick();
        repeat (4) drive_cycle(20, 20, 20, 10);
        chk("relock_after_reset", locked, 1'b1);

        // Randomized jitter, order swaps, overlaps, resets and clears.
        for (int c = 0; c < 40; c++) begin
            int h1, g1, h2, g2, mode;
            h1 = jit(20); g1 = jit(20); h2 = jit(20); g2 = jit(10);
            mode = int'($urandom_range(0, 11));
            if ($urandom_range(0, 7) == 0) begin
                err_clear = 1'b1; tick(); err_clear = 1'b0;
            end
            if (mode == 0) begin
                clk2_in = 1'b1; repeat (h2) tick();
                clk2_in = 1'b0; repeat (g2) tick();
                clk1_in = 1'b1; repeat (h1) tick();
                clk1_in = 1'b0; repeat (g1) tick();
            end else if (mode == 1) begin
                clk1_in = 1'b1; repeat (10) tick();
                clk2_in = 1'b1; repeat (10) tick();
                clk1_in = 1'b0; repeat (10) tick();
                clk2_in = 1'b0; repeat (10) tick();
            end else if (mode == 2) begin
                reset = 1'b1; tick(); reset = 1'b0;
                drive_cycle(h1, g1, h2, g2);
            end else begin
                drive_cycle(h1, g1, h2, g2);
            end
        end
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
